// File: rtl/ss_modulator_pkg.sv
// Shared definitions for the spread-spectrum modulator: register map, PRN field
// layout, datapath widths and the Galois LFSR step shared with the correlator.
package ss_modulator_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int PHASE_W   = 32;
  localparam int LUT_IDX_W = 13;

  localparam logic [31:0] OFF_CONTROL      = 32'h00;
  localparam logic [31:0] OFF_SAMPLE_DIV   = 32'h04;
  localparam logic [31:0] OFF_CARR_ADD     = 32'h08;
  localparam logic [31:0] OFF_CARR_PHASE   = 32'h0C;
  localparam logic [31:0] OFF_CHIP_FREQ    = 32'h10;
  localparam logic [31:0] OFF_CHIP_PHASE   = 32'h14;
  localparam logic [31:0] OFF_PRN          = 32'h18;
  localparam logic [31:0] OFF_AMP          = 32'h1C;
  localparam logic [31:0] OFF_EPOCH_COUNT  = 32'h20;
  localparam logic [31:0] OFF_SAMPLE_COUNT = 32'h24;

  localparam int PRN_HOB_LSB   = 28;
  localparam int PRN_POLY_LSB  = 14;
  localparam int PRN_STATE_LSB = 0;

  localparam logic [13:0] PRN_EPOCH_STATE = 14'h1;

  typedef struct packed {
    logic data_inv;
    logic run;
  } ctrl_t;

  // Galois step: drop the output bit, shift, fold in the polynomial if it was set.
  function automatic logic [13:0] lfsr_step(input logic [13:0] state,
                                            input logic [13:0] poly,
                                            input logic [3:0]  hob);
    logic [13:0] s;
    logic        b;
    b = state[hob];
    s = state;
    s[hob] = 1'b0;
    s = s << 1;
    if (b) s = s ^ poly;
    return s;
  endfunction

endpackage

// File: rtl/ss_modulator_sine.sv
// Quarter-wave sine table, first quadrant: index 0 -> 0, index 13'h1FFF -> 16'h7FFF.
// Parabolic shape u*(2-u), evaluated combinationally so it maps to a ROM or logic.
module sine (
  input  logic [12:0] v,
  output logic [15:0] sv
);

  logic [26:0] prod;

  assign prod = {14'd0, v} * (27'd16384 - {14'd0, v});
  assign sv   = 16'(prod >> 11);

endmodule

// File: rtl/ss_modulator.sv
// Spread-spectrum BPSK source: carrier/chip phase accumulators and PRN LFSR feed a
// three-stage sample pipeline (phase, LUT/sign, amplitude scale) behind a register bus.
module ss_modulator
  import ss_modulator_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFE000800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr,
  input  logic [31:0]         Wdata,
  input  logic                write,
  input  logic                read,
  output logic [31:0]         Rdata,
  output logic [SAMPLE_W-1:0] DAC,
  output logic                PushDAC,
  output logic                EpochStart
);

  ctrl_t                ctrl;
  logic [31:0]          sample_div, carr_add, chip_freq, prn;
  logic [PHASE_W-1:0]   carr_phase, chip_phase;
  logic [15:0]          amp;
  logic [31:0]          epoch_count, sample_count;
  logic [31:0]          div_cnt;
  logic                 epoch_pend;

  logic [31:0] off;
  logic wr_ctrl, wr_div, wr_cadd, wr_cph, wr_cfreq, wr_chph, wr_prn, wr_amp, wr_ecnt, wr_scnt;

  assign off      = addr - BASE_ADDR;
  assign wr_ctrl  = write && (off == OFF_CONTROL);
  assign wr_div   = write && (off == OFF_SAMPLE_DIV);
  assign wr_cadd  = write && (off == OFF_CARR_ADD);
  assign wr_cph   = write && (off == OFF_CARR_PHASE);
  assign wr_cfreq = write && (off == OFF_CHIP_FREQ);
  assign wr_chph  = write && (off == OFF_CHIP_PHASE);
  assign wr_prn   = write && (off == OFF_PRN);
  assign wr_amp   = write && (off == OFF_AMP);
  assign wr_ecnt  = write && (off == OFF_EPOCH_COUNT);
  assign wr_scnt  = write && (off == OFF_SAMPLE_COUNT);

  logic               tick, step, chip_bit;
  logic [PHASE_W-1:0] carr_next, chip_next;
  logic [13:0]        prn_state, prn_poly, stepped;
  logic [3:0]         prn_hob;

  assign tick      = ctrl.run && (div_cnt == '0);
  assign carr_next = carr_phase + carr_add;
  assign chip_next = chip_phase + chip_freq;
  assign prn_state = prn[PRN_STATE_LSB +: 14];
  assign prn_poly  = prn[PRN_POLY_LSB +: 14];
  assign prn_hob   = prn[PRN_HOB_LSB +: 4];
  assign chip_bit  = prn_state[prn_hob];
  assign step      = tick && !chip_phase[PHASE_W-1] && chip_next[PHASE_W-1];
  assign stepped   = lfsr_step(prn_state, prn_poly, prn_hob);

  logic                 s1_valid, s1_neg, s1_odd, s1_epoch;
  logic [LUT_IDX_W-1:0] s1_idx;
  logic                 s2_valid, s2_epoch;
  logic [SAMPLE_W-1:0]  s2_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!ctrl.run) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= sample_div;
    end else begin
      div_cnt <= div_cnt - 32'd1;
    end
  end

  // Bus writes win over the tick update of the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl         <= '0;
      sample_div   <= '0;
      carr_add     <= '0;
      carr_phase   <= '0;
      chip_freq    <= '0;
      chip_phase   <= '0;
      prn          <= '0;
      amp          <= '0;
      epoch_count  <= '0;
      sample_count <= '0;
      epoch_pend   <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl       <= ctrl_t'(Wdata[1:0]);
      if (wr_div)   sample_div <= Wdata;
      if (wr_cadd)  carr_add   <= Wdata;
      if (wr_cfreq) chip_freq  <= Wdata;
      if (wr_amp)   amp        <= Wdata[15:0];

      if (wr_cph)      carr_phase <= Wdata;
      else if (tick)   carr_phase <= carr_next;

      if (wr_chph)     chip_phase <= Wdata;
      else if (tick)   chip_phase <= chip_next;

      if (wr_prn)      prn <= Wdata;
      else if (step)   prn[PRN_STATE_LSB +: 14] <= stepped;

      if (tick)        epoch_pend <= step && (stepped == PRN_EPOCH_STATE);

      if (wr_ecnt)                    epoch_count <= Wdata;
      else if (s2_valid && s2_epoch)  epoch_count <= epoch_count + 32'd1;

      if (wr_scnt)       sample_count <= Wdata;
      else if (s2_valid) sample_count <= sample_count + 32'd1;
    end
  end

  logic [LUT_IDX_W-1:0] v;
  logic [SAMPLE_W-1:0]  sv, m;
  logic signed [33:0]   prod;

  assign v    = s1_odd ? ~s1_idx : s1_idx;
  assign m    = !s1_neg ? sv : ((sv == 16'h8000) ? 16'h7FFF : -sv);
  assign prod = $signed({s2_m[SAMPLE_W-1], s2_m}) * $signed({1'b0, amp});

  sine u_sine (
    .v  (v),
    .sv (sv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_neg     <= 1'b0;
      s1_odd     <= 1'b0;
      s1_epoch   <= 1'b0;
      s1_idx     <= '0;
      s2_valid   <= 1'b0;
      s2_epoch   <= 1'b0;
      s2_m       <= '0;
      DAC        <= '0;
      PushDAC    <= 1'b0;
      EpochStart <= 1'b0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1_neg   <= carr_phase[31] ^ chip_bit ^ ctrl.data_inv;
        s1_odd   <= carr_phase[30];
        s1_idx   <= carr_phase[29:17];
        s1_epoch <= epoch_pend;
      end
      s2_valid <= s1_valid;
      s2_m     <= m;
      s2_epoch <= s1_epoch;
      PushDAC    <= s2_valid;
      EpochStart <= s2_valid && s2_epoch;
      if (s2_valid) DAC <= 16'(prod >>> 16);
    end
  end

  always_comb begin
    Rdata = '0;
    if (!rst && read) begin
      case (off)
        OFF_CONTROL:      Rdata = {30'd0, ctrl};
        OFF_SAMPLE_DIV:   Rdata = sample_div;
        OFF_CARR_ADD:     Rdata = carr_add;
        OFF_CARR_PHASE:   Rdata = carr_phase;
        OFF_CHIP_FREQ:    Rdata = chip_freq;
        OFF_CHIP_PHASE:   Rdata = chip_phase;
        OFF_PRN:          Rdata = prn;
        OFF_AMP:          Rdata = {16'd0, amp};
        OFF_EPOCH_COUNT:  Rdata = epoch_count;
        OFF_SAMPLE_COUNT: Rdata = sample_count;
        default:          Rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/ss_modulator.md
# ss_modulator

Register-programmable spread-spectrum BPSK transmitter: carrier DDS, chip DDS and Galois PRN LFSR produce a 16-bit signed sample stream with a one-cycle push strobe. It is the signal source that drives the correlator's `ADC`/`PushADC` inputs in system benches and loopback configurations. It sits on the same 32-bit address/data register bus as the correlators.

## Interface
Parameters
- `BASE_ADDR`, 32'hFE000800: register window base; offsets below.

Ports
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `addr` in 32: bus address.
- `Wdata` in 32: bus write data.
- `write` in 1: write strobe, one cycle per access.
- `read` in 1: read strobe.
- `Rdata` out 32: combinational read data; 0 when `rst`, when `read`=0, or when the address is unmapped.
- `DAC` out 16: signed sample; holds its value between pushes.
- `PushDAC` out 1: one-cycle valid strobe for `DAC`.
- `EpochStart` out 1: pulses with the `PushDAC` of the first sample of each PRN epoch.

## Operation
Register map (offset: name); all R/W unless noted, all reset to 0:
- 0x00 Control: bit0 `run`, bit1 `data_inv`.
- 0x04 SampleDiv.
- 0x08 CarrAdd.
- 0x0C CarrPhase.
- 0x10 ChipFreq.
- 0x14 ChipPhase.
- 0x18 PRN: [31:28] hob, [27:14] poly, [13:0] state.
- 0x1C Amp: [15:0], unsigned Q0.16.
- 0x20 EpochCount: RO; a write loads it.
- 0x24 SampleCount: RO; a write loads it.

Tick generation:
- While `run`=1, a tick occurs every SampleDiv+1 clocks. The first tick is one clock after `run` is written to 1.
- `run`=0 stops ticks and resets the divider. Samples already in flight still emerge.

On each tick, using pre-update register values:
- CarrPhase += CarrAdd, modulo 2^32.
- ChipPhase += ChipFreq, modulo 2^32.
- The chip bit is `state[hob]`.
- If ChipPhase[31] goes 0→1 on this update, the LFSR steps once:
  - `b = state[hob]`.
  - `s = (state with bit hob cleared) << 1`, truncated to 14 bits.
  - If `b`=1, then `s ^= poly`.
  - The new state is `s`.
- If the LFSR steps and the new state == 14'h1, the epoch flag rides the pipeline with the next tick's sample.

Sample path:
- Quarter-wave index `v`:
  - CarrPhase[31:30] = 00 or 10: `v` = CarrPhase[29:17].
  - CarrPhase[31:30] = 01 or 11: `v` = ~CarrPhase[29:17].
- LUT output is `sv`, 16 bit.
- Sign flips are XOR-combined: negate once for each of CarrPhase[31], chip bit, and `data_inv` that is 1.
- The signed result `m` is 16 bit, two's complement. Negating 16'h8000 saturates to 16'h7FFF.
- `DAC` = (`m` × {0,Amp})[31:16], where the product is signed 17×17 and the shift is arithmetic.
- SampleCount increments on every `PushDAC`, modulo 2^32.
- EpochCount increments on every `EpochStart`, modulo 2^32.

Collisions:
- A bus write to a register takes priority over that register's tick update in the same cycle; other registers update normally.
- A write to PRN in the step cycle replaces the stepped value.

## Timing
- Tick in cycle T → `PushDAC`=1 in cycle T+3. Stages:
  - T+1: phase/LFSR register.
  - T+2: LUT/sign register.
  - T+3: multiply register.
- `EpochStart` is asserted in the same cycle as the corresponding `PushDAC`.
- With SampleDiv=0, a push occurs every clock; the pipeline is fully streaming with no stall.
- Reset values: `DAC`=0, `PushDAC`=0, `EpochStart`=0, all registers 0, pipeline valid bits cleared.
- Reset mid-stream discards all in-flight samples. No push follows reset until `run` is set again.

## Structure
Shared package holds:
- Register offsets.
- PRN field positions (hob/poly/state).
- `PRN_EPOCH_STATE` = 14'h1.
- Sample width 16.
- Phase width 32.
- LUT index width 13.

Sub-module: the existing `sine` quarter-wave LUT (`v`[12:0] → `sv`[15:0]) is instantiated unchanged, so transmitter and correlator references match bit-for-bit. LFSR step logic is a function in the package, shared with the correlator.

## Test plan
- Reset check: assert `rst` mid-run → `DAC`=0, `PushDAC`=0, `EpochStart`=0 within the same cycle; all reads return 0; no push until `run` is rewritten.
- Divider: SampleDiv=3, then `run`=1 → first `PushDAC` 4 clocks after the write cycle; subsequent pushes every 4 clocks; SampleCount=10 after 10 pushes.
- Carrier quadrants: CarrAdd=32'h4000_0000, ChipFreq=0, PRN state with `state[hob]`=0, Amp=16'hFFFF → `DAC` sequence 0, +P, 0, −P, repeating, where P = (LUT(13'h1FFF) × 16'hFFFF) >> 16. With `data_inv`=1, the same sequence negated.
- LFSR/epoch: PRN = {4'd3, 14'h3, 14'h1}, ChipFreq=32'h8000_0000 → LFSR steps every 2 ticks with states 2,4,8,3,6,C,B,5,A,7,E,F,D,9,1 (period 15); `EpochStart` every 30 pushes; EpochCount +1 per epoch.
- Write collision: write CarrPhase=32'h8000_0000 in a tick cycle → register reads 32'h8000_0000 (written value wins); next tick's sample uses quadrant 10 (negative half).
- Saturation: `m`=16'h8000 negated → 16'h7FFF before scaling; Amp=0 → `DAC`=0 with `PushDAC` still pulsing.
